stack_transfer_seq: RTL



---
 rtl/stack_transfer_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/stack_transfer_seq.sv
// PUSH/POP register-list sequencer: one register per memory beat in ascending order, SP written on completion.
// Latency k+2 cycles for k registers with zero-wait memory; each beat holds mem_req/addr/data until mem_ack.
module stack_transfer_seq #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = 16,
    localparam int WB   = DW / 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [NREGS-1:0] reglist,
    input  logic [AW-1:0]    sp_in,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic             sp_we,
    output logic [AW-1:0]    sp_out,
    output logic [RW-1:0]    rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_we,
    output logic [RW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_ack,
    input  logic             mem_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_FINISH = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             op_q;
    logic [NREGS-1:0] mask_q;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    sp_new_q;

    logic [AW-1:0]    list_bytes;
    logic [RW-1:0]    idx;
    logic [NREGS-1:0] mask_rem;
    logic             accept;
    logic             beat_ok;

    // Byte size of the whole list, accumulated modulo 2^AW so it never needs a multiplier.
    always_comb begin
        list_bytes = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reglist[i]) begin
                list_bytes = list_bytes + AW'(WB);
            end
        end
    end

    always_comb begin
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                idx = RW'(i);
            end
        end
    end

    always_comb begin
        mask_rem      = mask_q;
        mask_rem[idx] = 1'b0;
    end

    assign accept  = (state == S_IDLE) && start;
    assign beat_ok = (state == S_XFER) && mem_ack && !mem_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Full-descending stack: PUSH pre-decrements by the list size and then walks upward.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= 1'b0;
            mask_q   <= '0;
            addr_q   <= '0;
            sp_new_q <= '0;
        end else if (accept) begin
            op_q     <= op;
            mask_q   <= reglist;
            addr_q   <= op ? sp_in : (sp_in - list_bytes);
            sp_new_q <= op ? (sp_in + list_bytes) : (sp_in - list_bytes);
        end else if (beat_ok) begin
            mask_q   <= mask_rem;
            addr_q   <= addr_q + AW'(WB);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (reglist != '0) ? S_XFER : S_FINISH;
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    if (mem_err) begin
                        state_nxt = S_ABORT;
                    end else if (mask_rem == '0) begin
                        state_nxt = S_FINISH;
                    end
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        done      = 1'b0;
        fault     = 1'b0;
        sp_we     = 1'b0;
        sp_out    = '0;
        rf_raddr  = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_XFER: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                mem_we   = !op_q;
                if (!op_q) begin
                    rf_raddr  = idx;
                    mem_wdata = rf_rdata;
                end else if (mem_ack && !mem_err) begin
                    rf_we    = 1'b1;
                    rf_waddr = idx;
                    rf_wdata = mem_rdata;
                end
            end
            S_FINISH: begin
                done   = 1'b1;
                sp_we  = 1'b1;
                sp_out = sp_new_q;
            end
            S_ABORT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
